// File: rtl/decode_execute_stage.sv
// ID/EX pipeline register of the RV32I core with WB->ID write-through bypass and load-use bubble insertion.
// Latency: one cycle from decode-side inputs to EX-side outputs; the bypass and stall paths are combinational.
// Backpressure: HoldE freezes every EX register; a load-use hazard stalls IF/ID and sends a bubble into EX.
module decode_execute_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // register file read data and decode-side fields
    input  logic [DATA_WIDTH-1:0] RD1,
    input  logic [DATA_WIDTH-1:0] RD2,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic [DATA_WIDTH-1:0] ImmExtD,
    input  logic [31:0]           PCD,
    input  logic [31:0]           PCPlus4D,

    // decoded control
    input  logic                  RegWriteD,
    input  logic [1:0]            ResultSrcD,
    input  logic                  MemWriteD,
    input  logic                  JumpD,
    input  logic                  BranchD,
    input  logic [3:0]            ALUControlD,
    input  logic                  ALUSrcD,
    input  logic                  ValidD,

    // writeback port, used for the write-through bypass
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic [DATA_WIDTH-1:0] ResultW,

    // pipeline control from the hazard/branch logic
    input  logic                  FlushE,
    input  logic                  HoldE,

    // stall requests to the front end
    output logic                  StallF,
    output logic                  StallD,

    // EX-side datapath
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [DATA_WIDTH-1:0] ImmExtE,
    output logic [31:0]           PCE,
    output logic [31:0]           PCPlus4E,
    output logic [REG_ADDR_W-1:0] Rs1E,
    output logic [REG_ADDR_W-1:0] Rs2E,
    output logic [REG_ADDR_W-1:0] RdE,

    // EX-side control
    output logic                  RegWriteE,
    output logic [1:0]            ResultSrcE,
    output logic                  MemWriteE,
    output logic                  JumpE,
    output logic                  BranchE,
    output logic [3:0]            ALUControlE,
    output logic                  ALUSrcE,
    output logic                  ValidE
);

    // ResultSrc encoding that marks a load (data comes back from memory)
    localparam logic [1:0] RES_LOAD = 2'b01;

    // The whole EX register set; an all-zero value is a clean bubble
    // (no valid, no write, no store, no control transfer, ALU result select).
    typedef struct packed {
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [DATA_WIDTH-1:0] imm;
        logic [31:0]           pc;
        logic [31:0]           pc_plus4;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic                  jump;
        logic                  branch;
        logic [3:0]            alu_control;
        logic                  alu_src;
        logic                  valid;
    } ex_t;

    ex_t ex_q;
    ex_t ex_d;

    logic [DATA_WIDTH-1:0] operand1;
    logic [DATA_WIDTH-1:0] operand2;
    logic                  wb_hit1;
    logic                  wb_hit2;
    logic                  ex_is_load;
    logic                  src_match;
    logic                  load_use;
    logic                  bubble;

    // The register file writes on the clock edge, so a same-cycle read of the
    // register being written returns the old value; forward ResultW instead.
    // x0 is hardwired to zero whatever the register file drives.
    always_comb begin
        wb_hit1 = RegWriteW && (RdW != '0) && (RdW == Rs1D);
        wb_hit2 = RegWriteW && (RdW != '0) && (RdW == Rs2D);

        operand1 = RD1;
        if (Rs1D == '0) begin
            operand1 = '0;
        end else if (wb_hit1) begin
            operand1 = ResultW;
        end

        operand2 = RD2;
        if (Rs2D == '0) begin
            operand2 = '0;
        end else if (wb_hit2) begin
            operand2 = ResultW;
        end
    end

    // A load in EX whose destination feeds the decode instruction cannot be
    // forwarded in time: stall the front end and put one bubble into EX.
    always_comb begin
        ex_is_load = ex_q.valid && (ex_q.result_src == RES_LOAD) &&
                     ex_q.reg_write && (ex_q.rd != '0);
        src_match  = (ex_q.rd == Rs1D) || (ex_q.rd == Rs2D);
        load_use   = ex_is_load && ValidD && src_match;
        bubble     = FlushE || load_use;
        StallF     = load_use || HoldE;
        StallD     = load_use || HoldE;
    end

    // Assemble the next EX contents from the decode side (post-bypass operands).
    always_comb begin
        ex_d             = '0;
        ex_d.rd1         = operand1;
        ex_d.rd2         = operand2;
        ex_d.imm         = ImmExtD;
        ex_d.pc          = PCD;
        ex_d.pc_plus4    = PCPlus4D;
        ex_d.rs1         = Rs1D;
        ex_d.rs2         = Rs2D;
        ex_d.rd          = RdD;
        ex_d.reg_write   = RegWriteD;
        ex_d.result_src  = ResultSrcD;
        ex_d.mem_write   = MemWriteD;
        ex_d.jump        = JumpD;
        ex_d.branch      = BranchD;
        ex_d.alu_control = ALUControlD;
        ex_d.alu_src     = ALUSrcD;
        ex_d.valid       = ValidD;
    end

    // EX register update: hold beats flush/bubble, which beats a normal capture.
    // A flush seen during hold is dropped; the controller re-asserts it later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (HoldE) begin
            ex_q <= ex_q;
        end else if (bubble) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Drive the EX-side outputs straight from the register set.
    always_comb begin
        RD1E        = ex_q.rd1;
        RD2E        = ex_q.rd2;
        ImmExtE     = ex_q.imm;
        PCE         = ex_q.pc;
        PCPlus4E    = ex_q.pc_plus4;
        Rs1E        = ex_q.rs1;
        Rs2E        = ex_q.rs2;
        RdE         = ex_q.rd;
        RegWriteE   = ex_q.reg_write;
        ResultSrcE  = ex_q.result_src;
        MemWriteE   = ex_q.mem_write;
        JumpE       = ex_q.jump;
        BranchE     = ex_q.branch;
        ALUControlE = ex_q.alu_control;
        ALUSrcE     = ex_q.alu_src;
        ValidE      = ex_q.valid;
    end

endmodule

// File: tb/tb_decode_execute_stage.sv
// Directed bench for the ID/EX stage: reset, bypass, load-use, flush, hold and reset-during-stall.
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns after the edge or after input settle.
// Expected values are hand-computed constants for each vector.
module tb_decode_execute_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] RD1, RD2, ImmExtD, PCD, PCPlus4D, ResultW;
    logic [4:0]  Rs1D, Rs2D, RdD, RdW;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ValidD;
    logic [1:0]  ResultSrcD;
    logic [3:0]  ALUControlD;
    logic        RegWriteW, FlushE, HoldE;
    logic        StallF, StallD;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;

    int errors = 0;
    int checks = 0;

    decode_execute_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .RD1(RD1), .RD2(RD2), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .BranchD(BranchD), .ALUControlD(ALUControlD),
        .ALUSrcD(ALUSrcD), .ValidD(ValidD),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .FlushE(FlushE), .HoldE(HoldE),
        .StallF(StallF), .StallD(StallD),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .ValidE(ValidE)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // one comparison: count it and report any difference
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_d();
        RD1 = '0; RD2 = '0; ImmExtD = '0; PCD = '0; PCPlus4D = '0;
        Rs1D = '0; Rs2D = '0; RdD = '0;
        RegWriteD = 1'b0; ResultSrcD = 2'b00; MemWriteD = 1'b0; JumpD = 1'b0;
        BranchD = 1'b0; ALUControlD = '0; ALUSrcD = 1'b0; ValidD = 1'b0;
        RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    endtask

    // watchdog so the run always ends
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; FlushE = 1'b0; HoldE = 1'b0;
        clr_d();
        #3;
        check("rst_valid",  32'(ValidE), 32'd0);
        check("rst_rd1e",   RD1E, 32'd0);
        check("rst_stallf", 32'(StallF), 32'd0);
        check("rst_stalld", 32'(StallD), 32'd0);
        #9 rst_n = 1'b1;   // t=12, between edges

        // bypass on port 1, plain read on port 2
        ValidD = 1; RegWriteD = 1; Rs1D = 5; Rs2D = 6; RdD = 8;
        RD1 = 32'h11; RD2 = 32'h22; ImmExtD = 32'h100; PCD = 32'h40; PCPlus4D = 32'h44;
        ALUControlD = 4'd3; ALUSrcD = 1;
        RegWriteW = 1; RdW = 5; ResultW = 32'hDEADBEEF;
        step();
        check("byp_rd1e",   RD1E, 32'hDEADBEEF);
        check("byp_rd2e",   RD2E, 32'h22);
        check("cap_imm",    ImmExtE, 32'h100);
        check("cap_pc",     PCE, 32'h40);
        check("cap_pc4",    PCPlus4E, 32'h44);
        check("cap_rd",     32'(RdE), 32'd8);
        check("cap_rs1",    32'(Rs1E), 32'd5);
        check("cap_rs2",    32'(Rs2E), 32'd6);
        check("cap_aluc",   32'(ALUControlE), 32'd3);
        check("cap_alusrc", 32'(ALUSrcE), 32'd1);
        check("cap_regw",   32'(RegWriteE), 32'd1);
        check("cap_valid",  32'(ValidE), 32'd1);

        // RdW=0 never forwards; x0 source reads zero
        RdW = 0; Rs2D = 0; RD2 = 32'h55;
        step();
        check("rdw0_rd1e",  RD1E, 32'h11);
        check("x0_rd2e",    RD2E, 32'h0);

        // bypass on port 2; RegWriteW=0 blocks forwarding on port 1
        RegWriteW = 1; RdW = 6; Rs2D = 6; RD2 = 32'h22; ResultW = 32'hCAFE0006;
        step();
        check("byp_rd2e_b", RD2E, 32'hCAFE0006);
        RegWriteW = 0; RdW = 5; ResultW = 32'hDEADBEEF;
        step();
        check("nowe_rd1e",  RD1E, 32'h11);

        // load-use: load into EX, then dependent instruction in decode
        clr_d();
        ValidD = 1; RegWriteD = 1; ResultSrcD = 2'b01; RdD = 7; Rs1D = 1; Rs2D = 2;
        RD1 = 32'hA; RD2 = 32'hB;
        #1 check("nolu_stallf", 32'(StallF), 32'd0);
        step();
        check("ld_res_src", 32'(ResultSrcE), 32'd1);
        ResultSrcD = 2'b00; RdD = 10; Rs1D = 9; Rs2D = 7; RD1 = 32'h91; RD2 = 32'h77;
        #1;
        check("lu_stallf",  32'(StallF), 32'd1);
        check("lu_stalld",  32'(StallD), 32'd1);
        step();
        check("lu_bub_valid", 32'(ValidE), 32'd0);
        check("lu_bub_regw",  32'(RegWriteE), 32'd0);
        check("lu_bub_res",   32'(ResultSrcE), 32'd0);
        check("lu_bub_rd",    32'(RdE), 32'd0);
        check("lu_rel_stallf", 32'(StallF), 32'd0);
        step();
        check("lu_cap_valid", 32'(ValidE), 32'd1);
        check("lu_cap_rd",    32'(RdE), 32'd10);
        check("lu_cap_rd2e",  RD2E, 32'h77);
        check("lu_cap_stalld", 32'(StallD), 32'd0);

        // flush kills a store on its way into EX
        clr_d();
        ValidD = 1; MemWriteD = 1; RdD = 11; Rs1D = 4; RD1 = 32'h33; FlushE = 1;
        #1 check("fl_stallf", 32'(StallF), 32'd0);
        step();
        FlushE = 0;
        check("fl_memw",  32'(MemWriteE), 32'd0);
        check("fl_valid", 32'(ValidE), 32'd0);
        check("fl_rd1e",  RD1E, 32'd0);

        // ALU-result dependency is forwarded downstream, so no stall
        clr_d();
        ValidD = 1; RegWriteD = 1; RdD = 3; RD1 = 32'h1;
        step();
        Rs1D = 3; RdD = 12; RD1 = 32'h3C;
        #1 check("nl_stallf", 32'(StallF), 32'd0);
        step();
        check("nl_valid", 32'(ValidE), 32'd1);
        check("nl_rd",    32'(RdE), 32'd12);
        check("nl_rd1e",  RD1E, 32'h3C);

        // hold for three cycles while decode changes, then hold with flush
        HoldE = 1;
        for (int i = 0; i < 3; i++) begin
            RdD = 5'(13 + i); Rs1D = 5'(20 + i); RD1 = 32'h100 + 32'(i);
            #1 check("hd_stallf", 32'(StallF), 32'd1);
            step();
            check("hd_rd",   32'(RdE), 32'd12);
            check("hd_rd1e", RD1E, 32'h3C);
        end
        FlushE = 1;
        step();
        check("hdfl_valid", 32'(ValidE), 32'd1);
        check("hdfl_rd",    32'(RdE), 32'd12);
        HoldE = 0; FlushE = 0;

        // flush and load-use in the same cycle
        clr_d();
        ValidD = 1; RegWriteD = 1; ResultSrcD = 2'b01; RdD = 7;
        step();
        ResultSrcD = 2'b00; Rs1D = 7; RdD = 14; FlushE = 1;
        #1 check("fllu_stallf", 32'(StallF), 32'd1);
        step();
        FlushE = 0;
        check("fllu_valid", 32'(ValidE), 32'd0);
        check("fllu_res",   32'(ResultSrcE), 32'd0);

        // asynchronous reset in the middle of a stall
        clr_d();
        ValidD = 1; RegWriteD = 1; ResultSrcD = 2'b01; RdD = 7;
        step();
        ResultSrcD = 2'b00; Rs1D = 7; RdD = 15;
        #1;
        check("rs_pre_stallf", 32'(StallF), 32'd1);
        check("rs_pre_valid",  32'(ValidE), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_stallf", 32'(StallF), 32'd0);
        check("rs_stalld", 32'(StallD), 32'd0);
        check("rs_valid",  32'(ValidE), 32'd0);
        check("rs_rd",     32'(RdE), 32'd0);
        check("rs_res",    32'(ResultSrcE), 32'd0);
        #2 rst_n = 1'b1;
        step();
        check("rs_cap_valid", 32'(ValidE), 32'd1);
        check("rs_cap_rd",    32'(RdE), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_execute_stage.md
Name: decode_execute_stage

Overview:
- ID/EX pipeline stage of the 5-stage RV32I core; sits directly downstream of the register file.
- Captures register read data, immediate, PC values and decoded control into the EX-side register set.
- Provides a WB->ID write-through bypass, because the register file writes on the clock edge and a same-cycle read returns stale data.
- Contains load-use hazard detection, emitting stall requests to IF/ID and inserting bubbles into EX; honours branch/jump flush.

Parameters:
- DATA_WIDTH, 32, datapath width.
- REG_ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- RD1  in  DATA_WIDTH  register file read data, port 1.
- RD2  in  DATA_WIDTH  register file read data, port 2.
- Rs1D  in  REG_ADDR_W  source 1 address, decode.
- Rs2D  in  REG_ADDR_W  source 2 address, decode.
- RdD  in  REG_ADDR_W  destination address, decode.
- ImmExtD  in  DATA_WIDTH  extended immediate.
- PCD  in  32  decode PC.
- PCPlus4D  in  32  decode PC+4.
- RegWriteD  in  1  register write enable.
- ResultSrcD  in  2  result select: 00 ALU, 01 load, 10 PC+4.
- MemWriteD  in  1  store.
- JumpD  in  1  jump.
- BranchD  in  1  branch.
- ALUControlD  in  4  ALU op.
- ALUSrcD  in  1  immediate operand select.
- ValidD  in  1  decode slot holds a real instruction.
- RegWriteW  in  1  writeback write enable.
- RdW  in  REG_ADDR_W  writeback destination.
- ResultW  in  DATA_WIDTH  writeback data.
- FlushE  in  1  branch taken / jump in EX; kill the instruction entering EX.
- HoldE  in  1  external (memory) stall; freeze the whole stage.
- StallF  out  1  freeze PC.
- StallD  out  1  freeze IF/ID register.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE  out  as inputs  registered copies.
- RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE, ValidE  out  as inputs  registered control.

Behaviour:
- Reset: all outputs 0 asynchronously while rst_n is low. StallF and StallD are 0 during reset; ValidE is 0, so a bubble is in EX. Release is synchronous in effect: the first capture occurs on the first rising edge with rst_n high.
- Bypass (combinational): if RegWriteW, RdW != 0 and RdW == Rs1D, then operand1 = ResultW, else RD1. Same rule for Rs2D/RD2. An x0 source always yields 0, regardless of RD1/RD2.
- Load-use (combinational):
  - Condition: lu = ValidE & ResultSrcE==01 & RegWriteE & RdE != 0 & ValidD & (RdE==Rs1D | RdE==Rs2D).
  - StallF = StallD = lu | HoldE.
- Per-edge update priority:
  1. HoldE: all E registers keep their value. FlushE is ignored this cycle; the upstream controller re-asserts it.
  2. Else if FlushE or lu: bubble. ValidE, RegWriteE, MemWriteE, JumpE and BranchE go to 0, and ResultSrcE goes to 00. Datapath fields are don't-care but are loaded with 0.
  3. Else: capture all D-side values, with operands taken after the bypass.
- Latency: 1 cycle from D inputs to E outputs.
- Load-use produces exactly one bubble. On the next cycle EX no longer holds the load, lu drops, and the stalled instruction enters.
- Simultaneous FlushE and lu: bubble. StallF/StallD are still asserted for that cycle (harmless, because upstream is redirected).
- Asynchronous reset mid-stall clears the stall immediately.

Test Plan:
- Reset: rst_n=0 mid-run with ValidE=1 -> all E outputs 0 and StallF=0 immediately, before any clock edge.
- Bypass: RegWriteW=1, RdW=5, ResultW=0xDEADBEEF, Rs1D=5, RD1=0x11 -> RD1E=0xDEADBEEF after the edge. With RdW=0 instead -> RD1E=0x11.
- Load-use:
  - Setup: EX holds a load (ResultSrcE=01, RdE=7); decode has Rs2D=7.
  - Required: StallF=StallD=1 for 1 cycle, then ValidE=0 and RegWriteE=0 for 1 cycle.
  - Next cycle: the decode instruction is captured with ValidE=1 and the stall deasserted.
- Flush: FlushE=1 with MemWriteD=1, ValidD=1 -> MemWriteE=0 and ValidE=0 next cycle. StallF stays 0 when there is no hazard.
- Hold: HoldE=1 for 3 cycles while D inputs change -> E outputs unchanged and StallF=1 throughout. HoldE+FlushE together -> E unchanged.
- Non-load dependency: ResultSrcE=00, RdE=Rs1D=3 -> no stall, and the instruction is captured normally.
